// File: rtl/thermo_ctrl.sv
// Thermostat controller: captures a setpoint from an upstream configuration
// handshake and runs an IDLE/HEAT/COOL/HOLD loop with hysteresis and minimum dwell.
module thermo_ctrl #(
   parameter int unsigned BASE      = 16,
   parameter int unsigned HYST      = 1,
   parameter int unsigned MIN_DWELL = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hit,
   input  logic [3:0] cfg,
   input  logic [7:0] temp,
   input  logic       temp_vld,
   output logic       heat,
   output logic       cool,
   output logic [7:0] setpoint,
   output logic [1:0] mode
);

   localparam int unsigned DW = $clog2(MIN_DWELL + 1);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_HEAT = 2'b01;
   localparam logic [1:0] ST_COOL = 2'b10;
   localparam logic [1:0] ST_HOLD = 2'b11;

   localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
   localparam logic [DW-1:0] DWELL_ONE = DW'(1);
   localparam logic [7:0]    SP_RST    = 8'(BASE + 4);
   localparam logic [7:0]    SP_BASE   = 8'(BASE);
   localparam logic [8:0]    HYST9     = 9'(HYST);

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic [DW-1:0] dwell_r;
   logic [7:0]    setpoint_r;
   logic          hit_r;
   logic          hit_rise_s;
   logic          dwell_done_s;
   logic [8:0]    sp9_s;
   logic [8:0]    sp_lo_s;
   logic [8:0]    sp_hi_s;
   logic [8:0]    temp9_s;

   assign hit_rise_s   = hit & ~hit_r;
   assign dwell_done_s = (dwell_r == DWELL_MAX);

   // Hysteresis window from the setpoint held before this edge; lower bound clamps at zero.
   always_comb begin
      sp9_s   = {1'b0, setpoint_r};
      temp9_s = {1'b0, temp};
      sp_hi_s = sp9_s + HYST9;
      if (sp9_s >= HYST9) begin
         sp_lo_s = sp9_s - HYST9;
      end else begin
         sp_lo_s = 9'd0;
      end
   end

   // Next-state decision; every exit from IDLE/HEAT/COOL is gated by temp_vld.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (temp_vld && (temp9_s < sp_lo_s)) begin
               state_nxt_s = ST_HEAT;
            end else if (temp_vld && (temp9_s > sp_hi_s)) begin
               state_nxt_s = ST_COOL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HEAT: begin
            if (temp_vld && (temp9_s >= sp9_s) && dwell_done_s) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_HEAT;
            end
         end
         ST_COOL: begin
            if (temp_vld && (temp9_s <= sp9_s) && dwell_done_s) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_COOL;
            end
         end
         ST_HOLD: begin
            if (dwell_done_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register and dwell counter; the counter restarts on any state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         dwell_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (state_nxt_s != state_r) begin
            dwell_r <= '0;
         end else if (!dwell_done_s) begin
            dwell_r <= dwell_r + DWELL_ONE;
         end else begin
            dwell_r <= dwell_r;
         end
      end
   end

   // Setpoint capture on the rising edge of hit only; holding hit high never reloads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_r      <= 1'b0;
         setpoint_r <= SP_RST;
      end else begin
         hit_r <= hit;
         if (hit_rise_s) begin
            setpoint_r <= SP_BASE + {4'd0, cfg};
         end else begin
            setpoint_r <= setpoint_r;
         end
      end
   end

   assign heat     = (state_r == ST_HEAT);
   assign cool     = (state_r == ST_COOL);
   assign mode     = state_r;
   assign setpoint = setpoint_r;

endmodule

// File: tb/tb_thermo_ctrl.sv
// Self-checking bench for thermo_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_thermo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       hit = 1'b0;
   logic [3:0] cfg = 4'd0;
   logic [7:0] temp = 8'd0;
   logic       temp_vld = 1'b0;
   logic       heat;
   logic       cool;
   logic [7:0] setpoint;
   logic [1:0] mode;

   int checks = 0;
   int errors = 0;

   // Behavioural model: mode 0=IDLE 1=HEAT 2=COOL 3=HOLD, cycles spent in the mode, setpoint.
   int m_mode;
   int m_dwell;
   int m_sp;
   bit m_hit_prev;

   thermo_ctrl #(.BASE(16), .HYST(1), .MIN_DWELL(8)) dut (
      .clk(clk), .rst(rst), .hit(hit), .cfg(cfg), .temp(temp), .temp_vld(temp_vld),
      .heat(heat), .cool(cool), .setpoint(setpoint), .mode(mode)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_mode = 0;
      m_dwell = 0;
      m_sp = 20;
      m_hit_prev = 1'b0;
   endfunction

   function automatic void model_step();
      int old_sp;
      int t;
      int nxt;
      old_sp = m_sp;
      t = int'(temp);
      if (hit && !m_hit_prev) m_sp = 16 + int'(cfg);
      m_hit_prev = hit;
      nxt = m_mode;
      if (m_mode == 0) begin
         if (temp_vld && t < old_sp - 1) nxt = 1;
         else if (temp_vld && t > old_sp + 1) nxt = 2;
      end else if (m_mode == 1) begin
         if (temp_vld && t >= old_sp && m_dwell >= 8) nxt = 3;
      end else if (m_mode == 2) begin
         if (temp_vld && t <= old_sp && m_dwell >= 8) nxt = 3;
      end else begin
         if (m_dwell >= 8) nxt = 0;
      end
      if (nxt != m_mode) m_dwell = 0;
      else if (m_dwell < 8) m_dwell = m_dwell + 1;
      m_mode = nxt;
   endfunction

   function automatic logic [11:0] model_out();
      return {m_mode == 1, m_mode == 2, 2'(m_mode), 8'(m_sp)};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      #2;
      rst = 1'b0;
      model_reset();
      #7;
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      hit = 1'b0; temp_vld = 1'b0; temp = 8'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      #3;
      checks++;
      if ({heat, cool, mode, setpoint} !== {1'b0, 1'b0, 2'b00, 8'd20}) begin
         errors++;
         $display("FAIL reset_state got=%h want=%h", {heat, cool, mode, setpoint}, {1'b0, 1'b0, 2'b00, 8'd20});
      end
      // hit already high at release must register as a rising edge
      hit = 1'b1; cfg = 4'd3;
      #4;
      rst = 1'b1;
      tick();
      checks++;
      if (setpoint !== 8'd19) begin
         errors++;
         $display("FAIL reset_hit_high got=%0d want=19", setpoint);
      end
      hit = 1'b0;
      apply_reset();
   endtask

   task automatic test_config();
      hit = 1'b0; temp_vld = 1'b0;
      tick();
      hit = 1'b1; cfg = 4'd6;
      tick();
      checks++;
      if (setpoint !== 8'd22) begin
         errors++;
         $display("FAIL cfg_capture got=%0d want=22", setpoint);
      end
      cfg = 4'd9;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (setpoint !== 8'd22) begin
            errors++;
            $display("FAIL cfg_no_reload cycle=%0d got=%0d want=22", i, setpoint);
         end
      end
      hit = 1'b0;
      tick();
      hit = 1'b1;
      tick();
      checks++;
      if (setpoint !== 8'd25) begin
         errors++;
         $display("FAIL cfg_recapture got=%0d want=25", setpoint);
      end
      hit = 1'b0;
      apply_reset();
   endtask

   task automatic test_heat_cycle();
      temp = 8'd18; temp_vld = 1'b1;
      tick();
      checks++;
      if ({heat, cool, mode} !== 4'b1001) begin
         errors++;
         $display("FAIL heat_enter got=%b want=1001", {heat, cool, mode});
      end
      temp = 8'd20;
      // eight edges to fill the dwell counter, exit to HOLD on the ninth
      for (int i = 1; i <= 9; i++) begin
         tick();
         checks++;
         if (i < 9 && {heat, mode} !== 3'b101) begin
            errors++;
            $display("FAIL heat_dwell cycle=%0d got=%b want=101", i, {heat, mode});
         end else if (i == 9 && {heat, cool, mode} !== 4'b0011) begin
            errors++;
            $display("FAIL heat_to_hold got=%b want=0011", {heat, cool, mode});
         end
      end
      for (int i = 1; i <= 9; i++) begin
         tick();
         checks++;
         if (mode !== ((i < 9) ? 2'b11 : 2'b00)) begin
            errors++;
            $display("FAIL hold_dwell cycle=%0d got=%b want=%b", i, mode, (i < 9) ? 2'b11 : 2'b00);
         end
      end
      temp_vld = 1'b0;
      apply_reset();
   endtask

   task automatic test_hysteresis();
      logic [7:0] seq [4];
      logic [1:0] want [4];
      seq[0] = 8'd21; seq[1] = 8'd19; seq[2] = 8'd22; seq[3] = 8'd20;
      want[0] = 2'b00; want[1] = 2'b00; want[2] = 2'b10; want[3] = 2'b10;
      temp_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         temp = seq[i];
         tick();
         checks++;
         if ({cool, mode} !== {want[i] == 2'b10, want[i]}) begin
            errors++;
            $display("FAIL hysteresis temp=%0d got=%b want=%b", seq[i], {cool, mode}, {want[i] == 2'b10, want[i]});
         end
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({cool, mode} !== 3'b110) begin
            errors++;
            $display("FAIL cool_min_dwell cycle=%0d got=%b want=110", i, {cool, mode});
         end
      end
      temp_vld = 1'b0;
      apply_reset();
   endtask

   task automatic test_collision();
      temp = 8'd0; temp_vld = 1'b0;
      tick();
      checks++;
      if (mode !== 2'b00) begin
         errors++;
         $display("FAIL vld_gating got=%b want=00", mode);
      end
      // old setpoint 20 says heat (18<19); new 16 would say cool
      hit = 1'b1; cfg = 4'd0; temp = 8'd18; temp_vld = 1'b1;
      tick();
      checks++;
      if ({heat, cool, mode, setpoint} !== {4'b1001, 8'd16}) begin
         errors++;
         $display("FAIL hit_collision got=%b/%0d want=1001/16", {heat, cool, mode}, setpoint);
      end
      temp_vld = 1'b0;
   endtask

   task automatic test_async_reset();
      // still in HEAT from the collision scenario
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({heat, cool, mode, setpoint} !== {4'b0000, 8'd20}) begin
         errors++;
         $display("FAIL async_reset got=%b/%0d want=0000/20", {heat, cool, mode}, setpoint);
      end
      hit = 1'b0;
      #5;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) hit = ~hit;
         cfg = 4'($urandom);
         temp = 8'($urandom_range(10, 38));
         temp_vld = ($urandom_range(0, 3) != 0);
         tick();
         checks++;
         if ({heat, cool, mode, setpoint} !== model_out()) begin
            errors++;
            $display("FAIL random cycle=%0d got=%h want=%h", i, {heat, cool, mode, setpoint}, model_out());
         end
         checks++;
         if (heat && cool) begin
            errors++;
            $display("FAIL exclusive cycle=%0d got heat=1 cool=1 want not both", i);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_config();
      test_heat_cycle();
      test_hysteresis();
      test_collision();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/thermo_ctrl.md
THERMO_CTRL -- requirements
Module: thermo_ctrl

Parameters
REQ-001 BASE, 16, setpoint offset in degrees C added to the configuration code.
REQ-002 HYST, 1, hysteresis band in degrees C around the setpoint.
REQ-003 MIN_DWELL, 8, minimum cycles spent in HEAT, COOL or HOLD.

Interface
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 hit  input  1  configuration-done level from the upstream configuration FSM.
REQ-007 cfg  input  4  setpoint code from the upstream configuration FSM; valid while hit=1.
REQ-008 temp  input  8  measured temperature, unsigned degrees C.
REQ-009 temp_vld  input  1  temp is a valid sample this cycle.
REQ-010 heat  output  1  heater enable.
REQ-011 cool  output  1  cooler enable.
REQ-012 setpoint  output  8  active setpoint, unsigned degrees C.
REQ-013 mode  output  2  FSM state: IDLE=00, HEAT=01, COOL=10, HOLD=11.

Function
REQ-014 The block SHALL register hit and detect its rising edge (hit=1 this cycle, 0 the previous cycle).
REQ-015 On a detected rising edge the block SHALL load setpoint = BASE + cfg, zero-extended to 8 bits (range 16..31), at that clock edge.
REQ-016 While hit stays high after the rising edge, setpoint SHALL NOT reload, even if cfg changes.
REQ-017 Comparisons SHALL use the setpoint value held before the current edge. When a hit edge and temp_vld coincide, the old setpoint SHALL be used.
REQ-018 setpoint-HYST and setpoint+HYST SHALL be computed in 9 bits without wrap.
REQ-019 A dwell counter SHALL clear on every state change, increment each cycle otherwise, and saturate at MIN_DWELL.
REQ-020 IDLE: if temp_vld and temp < setpoint-HYST, the next state SHALL be HEAT. Else if temp_vld and temp > setpoint+HYST, the next state SHALL be COOL. Otherwise the FSM SHALL stay in IDLE.
REQ-021 HEAT: if temp_vld, temp >= setpoint and dwell counter = MIN_DWELL, the next state SHALL be HOLD. Otherwise the FSM SHALL stay in HEAT.
REQ-022 COOL: if temp_vld, temp <= setpoint and dwell counter = MIN_DWELL, the next state SHALL be HOLD. Otherwise the FSM SHALL stay in COOL.
REQ-023 HOLD: when the dwell counter = MIN_DWELL, the next state SHALL be IDLE. temp and temp_vld SHALL be ignored in HOLD.
REQ-024 heat SHALL be decoded from the state register (state==HEAT); cool SHALL be decoded likewise (state==COOL). Both SHALL change at the same edge as the state, with zero added latency.
REQ-025 heat and cool SHALL never both be 1.
REQ-026 When temp_vld=0, no transition out of IDLE, HEAT or COOL SHALL occur.
REQ-027 A setpoint change during HEAT or COOL SHALL take effect from the next cycle's comparison. The dwell counter SHALL NOT be affected.

Reset
REQ-028 While rst=0, the block SHALL force, without waiting for clk: mode=00, heat=0, cool=0, setpoint=BASE+4 (20), dwell counter=0, and the hit history register=0.
REQ-029 After reset release, a hit already high SHALL count as a rising edge on the first clock edge.
REQ-030 Reset asserted mid-HEAT or mid-COOL SHALL drop heat or cool asynchronously.

Verification
REQ-031 Reset: rst=0, then release -> heat=0, cool=0, mode=00, setpoint=20.
REQ-032 Config capture: hit 0->1 with cfg=6 -> setpoint=22 after that edge. Hold hit=1 for 5 cycles with cfg=9 -> setpoint stays 22. Drop hit, then raise it with cfg=9 -> setpoint=25.
REQ-033 Heat cycle at setpoint=20: temp=18 with temp_vld -> heat=1, mode=01. Next, temp=20 with temp_vld every cycle -> heat stays 1 until the dwell counter reaches 8, then mode=11. After 8 more cycles -> mode=00.
REQ-034 Hysteresis at setpoint=20: temp=21 and temp=19 -> stays IDLE. temp=22 -> cool=1, mode=10. temp=20 before 8 cycles elapse -> cool stays 1.
REQ-035 Gating and collision: temp=0 with temp_vld=0 -> stays IDLE. temp=18 with temp_vld=1 in the same cycle as a hit edge with cfg=0 (new setpoint 16) -> HEAT entered using the old setpoint 20.
REQ-036 Async reset: rst=0 between clock edges while heat=1 -> heat=0 immediately, setpoint=20.
